// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the {pc, ir} stream to decode.
// The master modport is the fetch stage; the slave modport is the memory/decode side.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_tvalid;
  logic        out_tready;
  logic [31:0] out_pc;
  logic [31:0] out_ir;

  modport master (
    output imem_req, imem_addr, out_tvalid, out_pc, out_ir,
    input  imem_rdata, out_tready
  );

  modport slave (
    input  imem_req, imem_addr, out_tvalid, out_pc, out_ir,
    output imem_rdata, out_tready
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: PC, synchronous imem reads and a credit-controlled skid FIFO to decode.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirects trap into a sticky HALT state.
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  fetch_if.master     bus,
  output logic        fault
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] S_HALT = 2'd3;
`endif

  logic [1:0]    state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic          inflight_reg;
  logic [31:0]   inflight_addr_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [31:0]   fifo_pc [DEPTH];
  logic [31:0]   fifo_ir [DEPTH];

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          push, pop, credit_ok;
  logic [CW:0]   used;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_reg;
  logic misalign;
  assign misalign    = (jump_target[1:0] != 2'b00);
  assign redirect    = jump_valid & (state_reg != S_HALT);
  assign redirect_pc = jump_target;
  assign fault       = fault_reg;
`else
  assign redirect    = jump_valid;
  assign redirect_pc = jump_target & 32'hFFFF_FFFC;
  assign fault       = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.out_tvalid = (count_reg != '0) & ~jump_valid;
  assign bus.out_pc     = fifo_pc[rd_ptr_reg];
  assign bus.out_ir     = fifo_ir[rd_ptr_reg];

  assign pop  = bus.out_tvalid & bus.out_tready;
  // A redirect discards the response landing this cycle: it belongs to the wrong path.
  assign push = inflight_reg & ~jump_valid;

  // Credits count the read already in flight so a full FIFO can never be overrun.
  assign used      = {1'b0, count_reg} + (CW + 1)'(inflight_reg) - (CW + 1)'(pop);
  assign credit_ok = (used < (CW + 1)'(DEPTH));

  assign bus.imem_req  = (state_reg == S_RUN) & ~stall & ~jump_valid & credit_ok;
  assign bus.imem_addr = pc_reg;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   if (stall) state_next = S_HOLD;
      default: state_next = state_reg;
    endcase
    if (bus.imem_req)
      pc_next = pc_reg + 32'd4;
    if (redirect) begin
      pc_next    = redirect_pc;
      state_next = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign)
        state_next = S_HALT;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= S_BOOT;
      pc_reg            <= RESET_ADDR;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= 32'h0;
      count_reg         <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_reg         <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      inflight_reg      <= bus.imem_req;
      inflight_addr_reg <= pc_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect && misalign)
        fault_reg <= 1'b1;
`endif
      if (redirect) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_reg] <= inflight_addr_reg;
      fifo_ir[wr_ptr_reg] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: queue-based reference model checked every cycle, plus literal pins.
module tb_fetch;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        fault;

  fetch_if bus ();

  fetch #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump_valid(jump_valid),
    .jump_target(jump_target), .bus(bus), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous instruction memory; garbage on idle cycles so stray captures show up.
  initial forever begin
    @(posedge clk);
    if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
    else              bus.imem_rdata <= $urandom;
  end

  // Reference model: every issued-but-unaccepted fetch sits in a queue with its issue cycle.
  typedef struct { logic [31:0] pc; int cyc; } ent_t;
  ent_t        q[$];
  logic        m_booted, m_holding, m_halted;
  logic [31:0] m_pc;
  int          m_cyc;
  logic        m_vis, m_valid, m_pop, m_req;

  initial begin
    m_booted = 0; m_holding = 0; m_halted = 0; m_pc = RESET_ADDR; m_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        m_booted = 0; m_holding = 0; m_halted = 0; m_pc = RESET_ADDR; m_cyc = 0;
      end else begin
        m_vis   = (q.size() > 0) && (m_cyc >= q[0].cyc + 2);
        m_valid = m_vis && !jump_valid && !m_halted;
        m_pop   = m_valid && bus.out_tready;
        m_req   = m_booted && !m_holding && !m_halted && !stall && !jump_valid &&
                  ((q.size() - (m_pop ? 1 : 0)) < DEPTH);
        check_eq("model_req", bus.imem_req, m_req);
        if (m_req) check_eq("model_addr", bus.imem_addr, m_pc);
        check_eq("model_tvalid", bus.out_tvalid, m_valid);
        if (m_valid) begin
          check_eq("model_pc", bus.out_pc, q[0].pc);
          check_eq("model_ir", bus.out_ir, mem_word(q[0].pc));
        end
        check_eq("model_fault", fault, m_halted);
        if (jump_valid && !m_halted) begin
          q.delete();
          m_holding = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (jump_target[1:0] != 2'b00) m_halted = 1;
          else m_pc = jump_target;
`else
          m_pc = jump_target & 32'hFFFF_FFFC;
`endif
        end else begin
          if (m_pop) void'(q.pop_front());
          if (m_req) begin
            q.push_back('{pc: m_pc, cyc: m_cyc});
            m_pc = m_pc + 32'd4;
          end
          if (m_booted && stall && !m_halted) m_holding = 1;
        end
        m_booted = 1;
        m_cyc++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int nreq;
  int stall_left;

  initial begin
    bus.out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); check_eq("boot_req", bus.imem_req, 0);
    @(negedge clk); check_eq("c1_req", bus.imem_req, 1); check_eq("c1_addr", bus.imem_addr, 32'h0);
    @(negedge clk); check_eq("c2_addr", bus.imem_addr, 32'h4);
    @(negedge clk); check_eq("c3_valid", bus.out_tvalid, 1); check_eq("c3_pc", bus.out_pc, 32'h0);
    @(negedge clk); check_eq("c4_pc", bus.out_pc, 32'h4);
    @(negedge clk); check_eq("c5_pc", bus.out_pc, 32'h8);

    // Back-pressure from the very first output.
    @(posedge clk); #1 reset = 1'b1; bus.out_tready = 1'b0;
    #1 check_eq("rst_tvalid", bus.out_tvalid, 0); check_eq("rst_req", bus.imem_req, 0);
    tick(); tick(); reset = 1'b0;
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.imem_req) nreq++;
      if (i >= 3) check_eq("bp_pc", bus.out_pc, 32'h0);
    end
    n_checks++;
    if (nreq <= 2) n_pass++;
    else $display("FAIL bp_reqs: got %0d expected at most 2", nreq);
    tick(); bus.out_tready = 1'b1;
    repeat (6) tick();

    // Stall, then redirect to 0x100.
    stall = 1'b1; nreq = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.imem_req) nreq++;
    end
    check_eq("stall_reqs", nreq, 0);
    tick(); stall = 1'b0; jump_valid = 1'b1; jump_target = 32'h100;
    tick(); jump_valid = 1'b0;
    @(negedge clk); check_eq("jmp_req", bus.imem_req, 1); check_eq("jmp_addr", bus.imem_addr, 32'h100);
    @(negedge clk);
    @(negedge clk); check_eq("jmp_valid", bus.out_tvalid, 1); check_eq("jmp_pc", bus.out_pc, 32'h100);

    // Redirect together with stall.
    tick(); stall = 1'b1; jump_valid = 1'b1; jump_target = 32'h40;
    tick(); stall = 1'b0; jump_valid = 1'b0;
    @(negedge clk); check_eq("js_req", bus.imem_req, 1); check_eq("js_addr", bus.imem_addr, 32'h40);

    // Randomized traffic: back-pressure, stall windows closed by redirects, wrap-around targets.
    stall_left = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      bus.out_tready = ($urandom_range(0, 3) != 0);
      jump_valid = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          stall = ($urandom_range(0, 3) == 0);
          jump_valid = 1'b1;
          jump_target = $urandom & 32'h0000_0FFC;
        end
      end else begin
        stall = 1'b0;
        if ($urandom_range(0, 11) == 0) begin
          stall = 1'b1;
          stall_left = $urandom_range(1, 5);
        end else if ($urandom_range(0, 19) == 0) begin
          jump_valid = 1'b1;
          jump_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
        end
      end
    end
    tick(); stall = 1'b0; jump_valid = 1'b0; bus.out_tready = 1'b0;

    // Fill the FIFO, then reset asynchronously mid-cycle.
    repeat (6) tick();
    @(negedge clk); check_eq("full_valid", bus.out_tvalid, 1);
    @(posedge clk); #3 reset = 1'b1;
    #1 check_eq("arst_tvalid", bus.out_tvalid, 0);
    check_eq("arst_req", bus.imem_req, 0);
    check_eq("arst_fault", fault, 0);
    tick(); reset = 1'b0; bus.out_tready = 1'b1;
    @(negedge clk); check_eq("re_boot_req", bus.imem_req, 0);
    @(negedge clk); check_eq("re_req", bus.imem_req, 1); check_eq("re_addr", bus.imem_addr, RESET_ADDR);

    // Misaligned redirect.
    repeat (4) tick();
    jump_valid = 1'b1; jump_target = 32'h102;
    tick(); jump_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("mis_fault", fault, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("mis_noreq", bus.imem_req, 0);
      @(negedge clk);
    end
`else
    check_eq("mis_req", bus.imem_req, 1);
    check_eq("mis_addr", bus.imem_addr, 32'h100);
    check_eq("mis_fault", fault, 0);
`endif
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage: holds the program counter, issues word reads to a synchronous instruction memory, and delivers {pc, ir} pairs to decode over a valid/ready stream. It sits directly upstream of decode. It consumes the `stall` output of the hazard unit to stop issuing past an unresolved control transfer, and it consumes the execute-stage redirect to restart on the correct path. A small credit-controlled skid FIFO absorbs in-flight reads when decode back-pressures.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, first PC fetched after reset; must be word aligned.
- DEPTH, 2, skid FIFO entries; legal values are 2 or greater. A value of 2 sustains one instruction per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; decode holds a JAL/JALR/BRANCH; stop issuing new reads.
- jump_valid  in  1  execute resolved a control transfer; redirect to jump_target.
- jump_target  in  32  next PC after the transfer; execute supplies pc+4 for a not-taken branch.
- imem_req  out  1  read request this cycle.
- imem_addr  out  32  word-aligned read address.
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
- out_tvalid  out  1  {out_pc, out_ir} valid to decode.
- out_tready  in  1  decode accepts.
- out_pc  out  32  PC of the presented instruction.
- out_ir  out  32  presented instruction word.
- fault  out  1  misaligned redirect trap; see Configuration.

## Operation
- State machine has three states.
  - BOOT: entered on reset. Leaves for RUN on the first clock edge after reset deasserts.
  - RUN: issuing reads.
  - HOLD: entered from RUN when `stall`=1. Returns to RUN on `jump_valid`.
  - HALT: see Configuration.
- Issue condition: `imem_req` = (state==RUN) & ~stall & ~jump_valid & (count + inflight − pop < DEPTH).
  - pop = out_tvalid & out_tready.
  - inflight = imem_req registered one cycle.
- On issue, `imem_addr` = pc, and pc ← pc + 4. The next PC wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Each response is pushed into the FIFO with its address, in the cycle after the request.
- `out_tvalid` = FIFO nonempty & ~jump_valid. The head of the FIFO drives out_pc and out_ir.
- Redirect (`jump_valid`=1) does all of the following in the same cycle:
  - flush the FIFO;
  - mark any in-flight response for discard, so it is not pushed next cycle;
  - set pc ← jump_target;
  - set state ← RUN;
  - no pop occurs, because out_tvalid is masked.
- Simultaneous events:
  - `jump_valid` overrides `stall`.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - A full FIFO never overflows, because credit accounting includes the in-flight read.
- Data held in the FIFO is stable while out_tvalid=1 and out_tready=0.

## Timing
- Reset values:
  - out_tvalid=0, imem_req=0, fault=0.
  - pc=RESET_ADDR, count=0, inflight=0, state=BOOT.
- Reset asserted mid-operation immediately discards all FIFO contents and any in-flight read.
- Latency:
  - Request at cycle t produces out_tvalid at t+2.
  - The first request is in cycle 1 after reset release, so the first out_tvalid is in cycle 3.
  - Redirect at cycle t: request to jump_target at t+1, out_tvalid at t+3.
- Throughput: one instruction per cycle with out_tready held at 1 and stall at 0.
- `stall` rising at cycle t:
  - no request in cycle t;
  - a request issued in t−1 still lands in the FIFO, and is flushed by the later redirect.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - a redirect with jump_target[1:0] ≠ 0 sets fault=1 on the next edge;
  - the state machine enters HALT, with no requests and out_tvalid=0;
  - it stays there until reset.
- Not defined:
  - jump_target[1:0] is forced to 0;
  - fault is tied to 0;
  - the HALT state does not exist.

## Test plan
- Reset release with RESET_ADDR=0 and out_tready=1: imem_addr sequence 0, 4, 8, …; first out_tvalid in cycle 3, then pc 0, 4, 8 on consecutive cycles.
- Hold out_tready=0 for 5 cycles after the first output: at most 2 requests are issued; out_pc stays 0; after release, pc 0, 4, 8 appear with no gaps or duplicates.
- stall=1 for 4 cycles, then jump_valid with target 32'h100: no requests during stall; FIFO flushed; next out_pc = 32'h100, with no stale pc after it.
- jump_valid and stall asserted together with target 32'h40: redirect taken; request at 32'h40 in the next cycle.
- Assert reset mid-stream with the FIFO full: outputs return to their reset values asynchronously; after release, fetch restarts at RESET_ADDR.
- With FETCH_MISALIGN_TRAP_EN, redirect to 32'h102: fault=1 and no further requests. Without the macro, the same redirect fetches 32'h100.
